// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes MIPS-style conditional branches and resolves them
// against the operands. It also computes the target and redirect PC, flags a
// mispredict against the fetch prediction, and trains a bimodal BHT that fetch
// reads combinationally. There is one register stage with a valid/ready handshake.
module branch_resolve_unit #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [5:0]        OpCode,
  input  logic [4:0]        Rt,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [PC_W-1:0]   PC,
  input  logic [15:0]       Imm,
  input  logic              Pred_Taken,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Is_Branch,
  output logic              Taken,
  output logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   Redirect_PC,
  output logic              Mispredict,
  input  logic [PC_W-1:0]   Lookup_PC,
  output logic              Lookup_Taken,
  output logic [CNT_W-1:0]  Branch_Count,
  output logic [CNT_W-1:0]  Mispred_Count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic              ov_q, ov_d, br_q, br_d, tk_q, tk_d, mp_q, mp_d;
  logic [PC_W-1:0]   tgt_q, tgt_d, rpc_q, rpc_d;
  logic [CNT_W-1:0]  bc_q, bc_d, mc_q, mc_d;
  logic [1:0]        bht_q [BHT_ENTRIES];
  logic              br_c, tk_c, mp_c, accept, a_neg, a_zero;
  logic [PC_W-1:0]   pc4_c, tgt_c, imm_ext;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        cnt_cur, cnt_new;
  logic              unused_lookup_bits;

  assign In_Ready = !ov_q || Out_Ready;
  assign accept   = In_Valid && In_Ready && !Flush;

  assign a_neg   = A[DATA_W-1];
  assign a_zero  = (A == '0);
  assign imm_ext = {{(PC_W-16){Imm[15]}}, Imm};
  assign pc4_c   = PC + PC_W'(4);
  assign tgt_c   = pc4_c + (imm_ext << 2);
  assign mp_c    = br_c && (tk_c != Pred_Taken);

  // Decode the opcode/REGIMM subcode and evaluate the signed branch condition.
  always_comb begin
    br_c = 1'b0;
    tk_c = 1'b0;
    case (OpCode)
      6'b000100: begin br_c = 1'b1; tk_c = (A == B); end
      6'b000101: begin br_c = 1'b1; tk_c = (A != B); end
      6'b000110: begin br_c = 1'b1; tk_c = a_neg || a_zero; end
      6'b000111: begin br_c = 1'b1; tk_c = !a_neg && !a_zero; end
      6'b000001: begin
        if (Rt == 5'd0)      begin br_c = 1'b1; tk_c = a_neg;  end
        else if (Rt == 5'd1) begin br_c = 1'b1; tk_c = !a_neg; end
      end
      default: ;
    endcase
  end

  // Output stage next state: flush wins, an accept loads, a lone Out_Ready drains.
  always_comb begin
    ov_d  = ov_q;
    br_d  = br_q;
    tk_d  = tk_q;
    mp_d  = mp_q;
    tgt_d = tgt_q;
    rpc_d = rpc_q;
    bc_d  = bc_q;
    mc_d  = mc_q;
    if (Flush) begin
      ov_d = 1'b0;
    end else if (accept) begin
      ov_d  = 1'b1;
      br_d  = br_c;
      tk_d  = tk_c;
      mp_d  = mp_c;
      tgt_d = tgt_c;
      rpc_d = tk_c ? tgt_c : pc4_c;
      if (br_c && bc_q != '1) bc_d = bc_q + CNT_W'(1);
      if (mp_c && mc_q != '1) mc_d = mc_q + CNT_W'(1);
    end else if (Out_Ready) begin
      ov_d = 1'b0;
    end
  end

  // Result and statistics registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ov_q  <= 1'b0;
      br_q  <= 1'b0;
      tk_q  <= 1'b0;
      mp_q  <= 1'b0;
      tgt_q <= '0;
      rpc_q <= '0;
      bc_q  <= '0;
      mc_q  <= '0;
    end else begin
      ov_q  <= ov_d;
      br_q  <= br_d;
      tk_q  <= tk_d;
      mp_q  <= mp_d;
      tgt_q <= tgt_d;
      rpc_q <= rpc_d;
      bc_q  <= bc_d;
      mc_q  <= mc_d;
    end
  end

  assign upd_idx = PC[IDX_W+1:2];
  assign cnt_cur = bht_q[upd_idx];

  // Saturating 2-bit counter step for the entry being trained.
  always_comb begin
    cnt_new = cnt_cur;
    if (tk_c && cnt_cur != 2'd3)       cnt_new = cnt_cur + 2'd1;
    else if (!tk_c && cnt_cur != 2'd0) cnt_new = cnt_cur - 2'd1;
  end

  // BHT storage: resets to weakly not-taken, trained only by accepted branches.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (accept && br_c) begin
      bht_q[upd_idx] <= cnt_new;
    end
  end

  // Fetch read port; reads the registered array, so same-cycle updates are not visible.
  assign Lookup_Taken       = bht_q[Lookup_PC[IDX_W+1:2]][1];
  assign unused_lookup_bits = ^{Lookup_PC[PC_W-1:IDX_W+2], Lookup_PC[1:0]};

  assign Out_Valid     = ov_q;
  assign Is_Branch     = br_q;
  assign Taken         = tk_q;
  assign Mispredict    = mp_q;
  assign Target        = tgt_q;
  assign Redirect_PC   = rpc_q;
  assign Branch_Count  = bc_q;
  assign Mispred_Count = mc_q;

endmodule
